// File: rtl/instr_fetch_axil_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// AXI4-Lite constants and a word-alignment helper.
package instr_fetch_axil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0]  ARPROT_INSTR  = 3'b100;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_axil.sv
// Instruction fetch stage: holds the PC, issues one AXI4-Lite read per
// instruction, presents the word to the decoder over valid/ready and
// drops fetches made stale by a redirect.
module instr_fetch_axil
  import instr_fetch_axil_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] m_axil_araddr,
  output logic [2:0]  m_axil_arprot,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_err
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        discard_q, discard_d;
  logic        capture;
  logic [31:0] target;

  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_err_q;

  // Outputs decode from state and registers only, so no input reaches an
  // output combinationally.
  assign m_axil_araddr  = pc_q;
  assign m_axil_arprot  = ARPROT_INSTR;
  assign m_axil_arvalid = (state_q == ADDR);
  assign m_axil_rready  = (state_q == DATA);
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_err      = instr_err_q;

  assign target = word_align(redirect_pc);

  // Next-state, PC and discard bookkeeping.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    discard_d = discard_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = ADDR;
        if (redirect_valid) pc_d = target;
      end
      ADDR: begin
        if (m_axil_arready) state_d = DATA;
        // AR must stay stable once presented, so a redirect here can only
        // mark the eventual beat as stale.
        if (redirect_valid) begin
          discard_d = 1'b1;
          pending_d = target;
        end
      end
      DATA: begin
        if (m_axil_rvalid) begin
          state_d = ADDR;
          if (redirect_valid) begin
            pc_d      = target;
            discard_d = 1'b0;
          end else if (discard_q) begin
            pc_d      = pending_q;
            discard_d = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
          pending_d = target;
        end
      end
      HOLD: begin
        // A redirect outranks a simultaneous consume; the held word is dropped.
        if (redirect_valid) begin
          pc_d    = target;
          state_d = ADDR;
        end else if (instr_ready) begin
          pc_d    = instr_pc_q + 32'd4;
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // PC, redirect bookkeeping and the registered instruction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= word_align(RESET_PC);
      pending_q   <= '0;
      discard_q   <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      if (capture) begin
        instr_pc_q  <= pc_q;
        instr_err_q <= (m_axil_rresp != AXI_RESP_OKAY);
        instr_q     <= (m_axil_rresp == AXI_RESP_OKAY) ? m_axil_rdata : INSTR_NOP;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_axil.sv
// Scoreboard bench for instr_fetch_axil: directed scenarios push expected
// AR addresses and instructions; a monitor pops and compares on handshakes.
module tb_instr_fetch_axil;

  localparam logic [31:0] RST_PC  = 32'h0000_1000;
  localparam logic [31:0] NO_ERR  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;

  instr_fetch_axil #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_axil_araddr  (araddr),
    .m_axil_arprot  (arprot),
    .m_axil_arvalid (arvalid),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rresp   (rresp),
    .m_axil_rvalid  (rvalid),
    .m_axil_rready  (rready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int at; } ar_exp_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } in_exp_t;

  ar_exp_t ar_q[$];
  in_exp_t in_q[$];

  int errors = 0;
  int checks = 0;

  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [31:0] err_addr = NO_ERR;
  int          c0 = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave memory contents: upper half carries the address so a wrong
  // PC/data pairing is visible.
  function automatic logic [31:0] beat(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  // AXI4-Lite read slave with programmable AR and R wait states.
  initial begin : slave
    int          ar_wait;
    int          r_wait;
    logic        pend;
    logic [31:0] raddr;
    logic [31:0] hs_addr;
    logic        ar_hs;
    logic        r_hs;
    ar_wait = 0; r_wait = 0; pend = 1'b0; raddr = '0; hs_addr = '0;
    ar_hs = 1'b0; r_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_wait = 0; r_wait = 0; pend = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      end else begin
        if (r_hs) pend = 1'b0;
        if (ar_hs) begin
          pend = 1'b1; raddr = hs_addr; r_wait = 0; ar_wait = 0;
        end
        arready = 1'b0;
        if (arvalid && !pend) begin
          if (ar_wait >= ar_delay) arready = 1'b1;
          else ar_wait++;
        end
        rvalid = 1'b0; rdata = '0; rresp = '0;
        if (pend) begin
          if (r_wait >= r_delay) begin
            rvalid = 1'b1;
            rdata  = beat(raddr);
            rresp  = (raddr == err_addr) ? 2'b10 : 2'b00;
          end else r_wait++;
        end
        ar_hs   = arvalid && arready;
        hs_addr = araddr;
        r_hs    = rvalid && rready;
      end
    end
  end

  // Monitor: scoreboard pops on handshakes plus stability/protocol checks.
  initial begin : monitor
    logic        p_rst, p_arv, p_arr, p_iv, p_ir, p_redir, p_err;
    logic [31:0] p_araddr, p_instr, p_pc;
    ar_exp_t     ea;
    in_exp_t     ei;
    p_rst = 1'b1; p_arv = 1'b0; p_arr = 1'b0; p_iv = 1'b0; p_ir = 1'b0;
    p_redir = 1'b0; p_err = 1'b0; p_araddr = '0; p_instr = '0; p_pc = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (arvalid && arready) begin
          if (ar_q.size() == 0) begin
            check32("ar_unexpected", araddr, 32'hxxxx_xxxx);
          end else begin
            ea = ar_q.pop_front();
            check32("araddr", araddr, ea.addr);
            if (ea.at >= 0) check32("ar_cycle", cyc - c0, ea.at - c0);
          end
        end
        if (instr_valid && instr_ready) begin
          if (in_q.size() == 0) begin
            check32("instr_unexpected", instr_pc, 32'hxxxx_xxxx);
          end else begin
            ei = in_q.pop_front();
            check32("instr_pc", instr_pc, ei.pc);
            check32("instr", instr, ei.data);
            check32("instr_err", {31'd0, instr_err}, {31'd0, ei.err});
          end
        end
        check32("ar_exclusive", {31'd0, arvalid && (rready || instr_valid)}, 32'd0);
        if (!p_rst && p_arv && !p_arr) begin
          check32("ar_hold_valid", {31'd0, arvalid}, 32'd1);
          check32("ar_hold_addr", araddr, p_araddr);
        end
        if (!p_rst && p_iv && !p_ir && !p_redir) begin
          check32("hold_valid", {31'd0, instr_valid}, 32'd1);
          check32("hold_instr", instr, p_instr);
          check32("hold_pc", instr_pc, p_pc);
          check32("hold_err", {31'd0, instr_err}, {31'd0, p_err});
        end
      end
      p_rst = rst; p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_iv = instr_valid; p_ir = instr_ready; p_redir = redirect_valid;
      p_instr = instr; p_pc = instr_pc; p_err = instr_err;
    end
  end

  // Called at a falling edge; returns at the falling edge of cycle 0.
  task automatic do_reset(input int ard, input int rd, input logic [31:0] ea);
    rst = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    ar_delay = ard; r_delay = rd; err_addr = ea;
    repeat (2) @(negedge clk);
    check32("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check32("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_araddr", araddr, 32'h0000_1000);
    ar_q.delete();
    in_q.delete();
    rst = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ar_q.size() == 0 && in_q.size() == 0) break;
      @(negedge clk);
    end
    if (ar_q.size() != 0 || in_q.size() != 0) begin
      check32("timeout_pending", ar_q.size() + in_q.size(), 32'd0);
      ar_q.delete();
      in_q.delete();
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input int at);
    ar_exp_t e;
    e.addr = a; e.at = at;
    ar_q.push_back(e);
  endtask

  task automatic push_in(input logic [31:0] pc, input logic [31:0] d, input logic err);
    in_exp_t e;
    e.pc = pc; e.data = d; e.err = err;
    in_q.push_back(e);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check32("reset_arvalid", {31'd0, arvalid}, 32'd0);
    check32("reset_rready", {31'd0, rready}, 32'd0);
    check32("reset_araddr", araddr, 32'h0000_1000);
    check32("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("reset_instr", instr, 32'd0);
    check32("reset_instr_pc", instr_pc, 32'd0);
    check32("reset_instr_err", {31'd0, instr_err}, 32'd0);
    check32("arprot", {29'd0, arprot}, 32'd4);

    // Zero-wait stream: one instruction every 3 cycles.
    do_reset(0, 0, NO_ERR);
    instr_ready = 1'b1;
    push_ar(32'h0000_1000, c0 + 1);
    push_ar(32'h0000_1004, c0 + 4);
    push_ar(32'h0000_1008, c0 + 7);
    push_in(32'h0000_1000, 32'h1000_0093, 1'b0);
    push_in(32'h0000_1004, 32'h1004_0093, 1'b0);
    push_in(32'h0000_1008, 32'h1008_0093, 1'b0);
    wait_done(50);

    // Slow slave: AR stable for 3 wait states, R after 2.
    do_reset(3, 2, NO_ERR);
    instr_ready = 1'b1;
    push_ar(32'h0000_1000, c0 + 4);
    push_in(32'h0000_1000, 32'h1000_0093, 1'b0);
    wait_done(50);

    // Decoder stall in HOLD for 5 cycles.
    do_reset(0, 0, NO_ERR);
    push_ar(32'h0000_1000, c0 + 1);
    push_in(32'h0000_1000, 32'h1000_0093, 1'b0);
    repeat (3) @(negedge clk);
    check32("stall_in_hold", {31'd0, instr_valid}, 32'd1);
    repeat (5) @(negedge clk);
    check32("stall_no_ar", {31'd0, arvalid}, 32'd0);
    instr_ready = 1'b1;
    push_ar(32'h0000_1004, cyc + 1);
    wait_done(50);

    // Redirect during DATA with late R: stale beat dropped.
    do_reset(0, 3, NO_ERR);
    instr_ready = 1'b1;
    push_ar(32'h0000_1000, c0 + 1);
    push_ar(32'h0000_2000, -1);
    push_in(32'h0000_2000, 32'h2000_0093, 1'b0);
    repeat (3) @(negedge clk);
    check32("redir_in_data", {31'd0, rready}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_done(60);

    // Two redirects against one outstanding fetch: last one wins.
    do_reset(0, 4, NO_ERR);
    instr_ready = 1'b1;
    push_ar(32'h0000_1000, c0 + 1);
    push_ar(32'h0000_4000, -1);
    push_in(32'h0000_4000, 32'h4000_0093, 1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    @(negedge clk);
    redirect_pc = 32'h0000_4000;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_done(60);

    // Bus error on 0x1004 becomes a flagged NOP; sequencing continues.
    do_reset(0, 0, 32'h0000_1004);
    instr_ready = 1'b1;
    push_ar(32'h0000_1000, c0 + 1);
    push_ar(32'h0000_1004, c0 + 4);
    push_ar(32'h0000_1008, c0 + 7);
    push_in(32'h0000_1000, 32'h1000_0093, 1'b0);
    push_in(32'h0000_1004, 32'h0000_0013, 1'b1);
    push_in(32'h0000_1008, 32'h1008_0093, 1'b0);
    wait_done(50);

    // Redirect in IDLE to the top word, then PC wraps to 0.
    do_reset(0, 0, NO_ERR);
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    push_ar(32'hFFFF_FFFC, c0 + 1);
    push_ar(32'h0000_0000, c0 + 4);
    push_in(32'hFFFF_FFFC, 32'hFFFC_0093, 1'b0);
    push_in(32'h0000_0000, 32'h0000_0093, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_done(50);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
